// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch path.
//   fetch_state_t      : fetch FSM state encoding
//   KSEG_UNMAPPED_MASK : physical mask for unmapped kseg0/kseg1 addresses
//   PFN_W              : physical frame number width returned by the TLB
package cpu_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] KSEG_UNMAPPED_MASK = 32'h1FFF_FFFF;
  localparam int unsigned PFN_W              = 20;

endpackage

// File: rtl/inst_fetch_unit_xlate.sv
// fetch_addr_xlate: combinational virtual-to-physical translation for a fetch.
//   pc        in  32     virtual address
//   tlb_hit   in  1      TLB hit for pc[31:12]
//   tlb_pfn   in  PFN_W  frame number on hit
//   paddr     out 32     physical address
//   mapped    out 1      address goes through the TLB
//   miss      out 1      mapped and the TLB missed
//   unaligned out 1      pc[1:0] != 0
module fetch_addr_xlate
  import cpu_defs::*;
#(
  parameter bit USE_TLB = 1'b1
) (
  input  logic [31:0]      pc,
  input  logic             tlb_hit,
  input  logic [PFN_W-1:0] tlb_pfn,
  output logic [31:0]      paddr,
  output logic             mapped,
  output logic             miss,
  output logic             unaligned
);

  // kseg0/kseg1 (pc[31:30] == 2'b10) bypass the TLB
  assign mapped    = USE_TLB && (pc[31:30] != 2'b10);
  assign miss      = mapped && !tlb_hit;
  assign unaligned = (pc[1:0] != 2'b00);
  assign paddr     = mapped ? {tlb_pfn, pc[11:0]} : (pc & KSEG_UNMAPPED_MASK);

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch-side responder for the PC register. Translates pc,
// performs one read on the SRAM-like instruction bus, returns the instruction.
//   clock, reset        clock; synchronous active-low reset
//   pc                  current fetch address
//   pause               downstream stall, holds the delivered instruction
//   flush               exception flush, held until ready=1 is seen
//   tlb_vpn/hit/pfn     combinational TLB lookup port
//   bus_req/addr/ack/rdata  instruction bus (request held until ack)
//   ready               fetch slot complete (combinational)
//   inst_valid, inst, inst_pc, tlb_miss, addr_err  fetch result
module inst_fetch_unit
  import cpu_defs::*;
#(
  parameter bit USE_TLB = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pause,
  input  logic        flush,
  output logic [19:0] tlb_vpn,
  input  logic        tlb_hit,
  input  logic [19:0] tlb_pfn,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        tlb_miss,
  output logic        addr_err
);

  fetch_state_t state, state_n;

  logic [31:0] paddr;
  logic        mapped, miss, unaligned;

  logic        bus_req_n;
  logic [31:0] bus_addr_n;
  logic [31:0] inst_n, inst_pc_n;
  logic        valid_q, valid_n;
  logic        tlb_miss_n, addr_err_n;

  fetch_addr_xlate #(.USE_TLB(USE_TLB)) u_xlate (
    .pc        (pc),
    .tlb_hit   (tlb_hit),
    .tlb_pfn   (tlb_pfn),
    .paddr     (paddr),
    .mapped    (mapped),
    .miss      (miss),
    .unaligned (unaligned)
  );

  assign tlb_vpn = USE_TLB ? pc[31:12] : '0;

  assign ready = (state == S_RESP) || ((state == S_IDLE) && flush);

  // valid is registered, but a flush arriving while a result is on display
  // must hide it immediately so the exception unit never consumes it
  assign inst_valid = valid_q && !flush;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      inst     <= '0;
      inst_pc  <= '0;
      valid_q  <= 1'b0;
      tlb_miss <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_n;
      bus_req  <= bus_req_n;
      bus_addr <= bus_addr_n;
      inst     <= inst_n;
      inst_pc  <= inst_pc_n;
      valid_q  <= valid_n;
      tlb_miss <= tlb_miss_n;
      addr_err <= addr_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    bus_req_n  = bus_req;
    bus_addr_n = bus_addr;
    inst_n     = inst;
    inst_pc_n  = inst_pc;
    valid_n    = valid_q;
    tlb_miss_n = tlb_miss;
    addr_err_n = addr_err;

    unique case (state)
      S_IDLE: begin
        if (!flush) begin
          inst_pc_n  = pc;
          tlb_miss_n = 1'b0;
          addr_err_n = 1'b0;
          if (unaligned) begin
            addr_err_n = 1'b1;
            inst_n     = '0;
            valid_n    = 1'b1;
            state_n    = S_RESP;
          end else if (miss) begin
            tlb_miss_n = 1'b1;
            inst_n     = '0;
            valid_n    = 1'b1;
            state_n    = S_RESP;
          end else begin
            bus_addr_n = paddr;
            bus_req_n  = 1'b1;
            state_n    = S_BUS;
          end
        end
      end

      S_BUS: begin
        if (bus_ack) begin
          bus_req_n = 1'b0;
          if (flush) begin
            state_n = S_IDLE;
          end else begin
            inst_n  = bus_rdata;
            valid_n = 1'b1;
            state_n = S_RESP;
          end
        end else if (flush) begin
          state_n = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (bus_ack) begin
          bus_req_n = 1'b0;
          state_n   = S_IDLE;
        end
      end

      S_RESP: begin
        if (flush) begin
          tlb_miss_n = 1'b0;
          addr_err_n = 1'b0;
          valid_n    = 1'b0;
          state_n    = S_IDLE;
        end else if (!pause) begin
          valid_n = 1'b0;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pause;
  logic        flush;
  logic [19:0] tlb_vpn;
  logic        tlb_hit;
  logic [19:0] tlb_pfn;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata;
  logic        ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        tlb_miss;
  logic        addr_err;

  inst_fetch_unit #(.USE_TLB(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .pause      (pause),
    .flush      (flush),
    .tlb_vpn    (tlb_vpn),
    .tlb_hit    (tlb_hit),
    .tlb_pfn    (tlb_pfn),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .ready      (ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .tlb_miss   (tlb_miss),
    .addr_err   (addr_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        miss;
    logic        err;
  } deliv_t;

  deliv_t      dq[$];
  logic [31:0] bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Bus slave: acknowledges ack_delay cycles after bus_req is first seen
  int ack_delay = 0;
  int slave_cnt = 0;
  always begin
    @(posedge clock);
    #2;
    if (bus_req && !bus_ack) begin
      if (slave_cnt >= ack_delay) begin
        bus_ack   = 1'b1;
        slave_cnt = 0;
      end else begin
        slave_cnt++;
      end
    end else begin
      bus_ack   = 1'b0;
      slave_cnt = 0;
    end
  end

  // Monitor: new bus request and new instruction delivery pop the scoreboard
  logic prev_req = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    deliv_t      e;
    logic [31:0] a;
    if (bus_req && !prev_req) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected actual_addr=%h required=no_request", bus_addr);
      end else begin
        a = bq.pop_front();
        chk("bus_addr", bus_addr, a);
      end
    end
    if (inst_valid && !prev_valid) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliv_unexpected actual_pc=%h required=no_delivery", inst_pc);
      end else begin
        e = dq.pop_front();
        chk("deliv_inst", inst, e.inst);
        chk("deliv_pc", inst_pc, e.pc);
        chk("deliv_miss", {31'd0, tlb_miss}, {31'd0, e.miss});
        chk("deliv_err", {31'd0, addr_err}, {31'd0, e.err});
        chk("deliv_ready", {31'd0, ready}, 32'd1);
      end
    end
    prev_req   = bus_req;
    prev_valid = inst_valid;
  end

  logic [31:0] last_inst;

  task automatic fetch(input logic [31:0] a, input logic hit, input logic [19:0] pfn,
                       input logic [31:0] data, input int pause_cycles, input logic expect_bus,
                       input logic [31:0] exp_paddr, input logic miss, input logic err);
    int n;
    logic [31:0] exp_inst;
    deliv_t d;
    exp_inst = (miss || err) ? 32'd0 : data;
    if (expect_bus) bq.push_back(exp_paddr);
    d.inst = exp_inst; d.pc = a; d.miss = miss; d.err = err;
    dq.push_back(d);
    pc = a; tlb_hit = hit; tlb_pfn = pfn; bus_rdata = data; ack_delay = 0;
    flush = 1'b0;
    cyc();
    chk("tlb_vpn", {12'd0, tlb_vpn}, {12'd0, a[31:12]});
    n = 0;
    while (!(inst_valid && ready) && n < 20) begin
      cyc();
      n++;
    end
    chk("latency", n, expect_bus ? 32'd1 : 32'd0);
    if (pause_cycles > 0) begin
      pause = 1'b1;
      for (int i = 0; i < pause_cycles; i++) begin
        cyc();
        chk("pause_ready", {31'd0, ready}, 32'd1);
        chk("pause_valid", {31'd0, inst_valid}, 32'd1);
        chk("pause_inst", inst, exp_inst);
        chk("pause_pc", inst_pc, a);
        chk("pause_busreq", {31'd0, bus_req}, 32'd0);
      end
      pause = 1'b0;
    end
    cyc();
    flush = 1'b1;
    cyc();
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_valid", {31'd0, inst_valid}, 32'd0);
    chk("idle_busreq", {31'd0, bus_req}, 32'd0);
    last_inst = exp_inst;
  endtask

  task automatic chk_reset_vals();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_miss", {31'd0, tlb_miss}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
  endtask

  initial begin
    int n;
    deliv_t d;
    reset = 1'b0; flush = 1'b1; pause = 1'b0; pc = 32'hBFC0_0000;
    tlb_hit = 1'b0; tlb_pfn = '0; bus_rdata = '0; last_inst = '0;
    repeat (3) cyc();
    chk_reset_vals();
    chk("rst_ready_flush", {31'd0, ready}, 32'd1);
    reset = 1'b1;
    cyc();
    chk("idle_flush_busreq", {31'd0, bus_req}, 32'd0);

    fetch(32'hBFC0_0000, 1'b0, 20'h0,     32'h2408_0001, 0, 1'b1, 32'h1FC0_0000, 1'b0, 1'b0);
    fetch(32'h0040_0010, 1'b1, 20'h01234, 32'h8C08_0004, 0, 1'b1, 32'h0123_4010, 1'b0, 1'b0);
    fetch(32'hC000_1008, 1'b1, 20'h00ABC, 32'hAC09_0008, 0, 1'b1, 32'h00AB_C008, 1'b0, 1'b0);
    fetch(32'h0040_0010, 1'b0, 20'h01234, 32'hFFFF_FFFF, 0, 1'b0, 32'h0,         1'b1, 1'b0);
    fetch(32'h8000_0002, 1'b0, 20'h0,     32'hFFFF_FFFF, 0, 1'b0, 32'h0,         1'b0, 1'b1);
    fetch(32'h0040_0012, 1'b0, 20'h0,     32'hFFFF_FFFF, 0, 1'b0, 32'h0,         1'b0, 1'b1);
    fetch(32'hA000_0100, 1'b0, 20'h0,     32'h3C01_1234, 4, 1'b1, 32'h0000_0100, 1'b0, 1'b0);

    // flush while the bus is busy: request must be held until the ack
    bq.push_back(32'h1FC0_0004);
    pc = 32'hBFC0_0004; bus_rdata = 32'hDEAD_BEEF; ack_delay = 3;
    flush = 1'b0;
    cyc();
    chk("flush_busreq_start", {31'd0, bus_req}, 32'd1);
    flush = 1'b1;
    n = 0;
    while (bus_req && n < 10) begin
      chk("flush_ready_low", {31'd0, ready}, 32'd0);
      cyc();
      n++;
    end
    chk("flush_drain_len", n, 32'd4);
    chk("flush_idle_ready", {31'd0, ready}, 32'd1);
    chk("flush_idle_valid", {31'd0, inst_valid}, 32'd0);
    chk("flush_discard", inst, last_inst);
    repeat (2) cyc();
    chk("flush_no_refetch", {31'd0, bus_req}, 32'd0);

    // reset during S_BUS, then a fresh fetch of the same pc
    bq.push_back(32'h1FC0_0008);
    bq.push_back(32'h1FC0_0008);
    d.inst = 32'h2409_0002; d.pc = 32'hBFC0_0008; d.miss = 1'b0; d.err = 1'b0;
    dq.push_back(d);
    pc = 32'hBFC0_0008; bus_rdata = 32'h2409_0002; ack_delay = 10;
    flush = 1'b0;
    cyc();
    chk("rst_mid_busreq", {31'd0, bus_req}, 32'd1);
    reset = 1'b0;
    cyc();
    chk_reset_vals();
    reset = 1'b1;
    ack_delay = 0;
    n = 0;
    while (!(inst_valid && ready) && n < 20) begin
      cyc();
      n++;
    end
    chk("rst_refetch_latency", n, 32'd2);
    cyc();
    flush = 1'b1;
    repeat (2) cyc();

    chk("bus_queue_left", bq.size(), 32'd0);
    chk("deliv_queue_left", dq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side responder for the PC register.
- Takes the current PC, translates it (unmapped kseg0/kseg1 direct; other segments via TLB lookup port), runs one instruction read on the SRAM-like bus, and returns the instruction.
- Drives the `ready` and TLB-miss signals that the PC register consumes; holds `ready` low while a fetch is outstanding.
- Sits between the PC register, the TLB and the instruction bus, and feeds the IF/ID latch.

Parameters:
- USE_TLB, 1: 1 = kuseg/kseg2/kseg3 translated via the TLB port; 0 = every address maps to paddr = vaddr & 32'h1FFF_FFFF, and the TLB port is unused (tlb_vpn driven 0).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low
- pc  in  32  current fetch address from the PC register
- pause  in  1  downstream stall; holds the delivered instruction
- flush  in  1  exception flush; held by the exception unit until it sees ready=1
- tlb_vpn  out  20  pc[31:12] for the combinational TLB lookup
- tlb_hit  in  1  TLB hit for tlb_vpn, same cycle
- tlb_pfn  in  20  physical frame number on hit
- bus_req  out  1  read request; held until bus_ack
- bus_addr  out  32  physical word address, registered
- bus_ack  in  1  one-cycle acknowledge; bus_rdata valid in the same cycle
- bus_rdata  in  32  read data
- ready  out  1  fetch slot complete; PC register may advance
- inst_valid  out  1  inst/inst_pc carry a real instruction or fault
- inst  out  32  fetched instruction (0 on fault)
- inst_pc  out  32  virtual address of inst
- tlb_miss  out  1  fetch faulted on a TLB miss (to PCTLBMiss)
- addr_err  out  1  fetch faulted on pc[1:0] != 0

Behaviour:
- Reset (reset=0 at the clock edge) forces:
  - state=S_IDLE
  - bus_req=0, bus_addr=0
  - inst=0, inst_pc=0
  - inst_valid=0, tlb_miss=0, addr_err=0
- Reset mid-fetch drops bus_req immediately. The bus slave must tolerate an abandoned request.
- Segments:
  - pc[31:30]==2'b10 (kseg0/kseg1) is unmapped: paddr = pc & 32'h1FFF_FFFF.
  - Otherwise, with USE_TLB=1, paddr = {tlb_pfn, pc[11:0]} on tlb_hit.
- S_IDLE, flush=1: ready=1, inst_valid=0, no fetch started; stay in S_IDLE.
- S_IDLE, flush=0: evaluate the fault checks in priority order, then latch inst_pc=pc.
  - pc[1:0]!=0: addr_err=1, inst=0 -> S_RESP.
  - Else mapped and !tlb_hit: tlb_miss=1, inst=0 -> S_RESP.
  - Else: bus_addr=paddr -> S_BUS.
- S_BUS: bus_req=1, ready=0.
  - bus_ack: inst=bus_rdata -> S_RESP.
  - flush && !bus_ack -> S_DRAIN.
  - flush && bus_ack -> S_IDLE; data is discarded.
- S_DRAIN: bus_req=1, ready=0; on bus_ack discard data -> S_IDLE. flush is ignored here.
- S_RESP: ready=1, inst_valid = !flush.
  - flush: clear tlb_miss/addr_err -> S_IDLE.
  - else pause: hold all outputs, stay in S_RESP.
  - else -> S_IDLE.
- Output timing:
  - ready is combinational from state and flush.
  - All other outputs are registered.
  - tlb_miss/addr_err are valid only while inst_valid=1.
- Latency:
  - Unmapped hit with bus_ack on the first S_BUS cycle: PC sampled in cycle 0, ready=1 in cycle 2. That gives a 3-cycle fetch slot.
  - Fault case: ready=1 in cycle 1.
- At most one bus transaction is outstanding. A new request is never issued before the ack of the previous one.

Decomposition:
- Shared package (cpu_defs): fetch FSM state encoding (S_IDLE, S_BUS, S_DRAIN, S_RESP) and constants KSEG_UNMAPPED_MASK=32'h1FFF_FFFF and PFN_W=20.
- One natural sub-module: fetch_addr_xlate, combinational. Inputs: pc, tlb_hit, tlb_pfn, USE_TLB. Outputs: paddr, mapped, miss, unaligned. Reused later for the data-side fetch.

Test Plan:
- Reset then pc=32'hBFC0_0000 -> bus_addr=32'h1FC0_0000, bus_req=1. Ack on the first S_BUS cycle with rdata=32'h2408_0001 -> next cycle ready=1, inst_valid=1, inst=32'h2408_0001, inst_pc=32'hBFC0_0000.
- pc=32'h0040_0010, tlb_hit=1, tlb_pfn=20'h01234 -> bus_addr=32'h0123_4010. Same pc with tlb_hit=0 -> no bus_req, ready=1 after 1 cycle, tlb_miss=1, inst=0.
- pc=32'h8000_0002 -> addr_err=1, inst_valid=1, bus_req never asserted.
- flush raised during S_BUS, bus_ack delayed 3 cycles -> bus_req stays 1 until the ack, ready=0 until the ack. Then S_IDLE with flush still high -> ready=1, inst_valid=0, rdata discarded.
- pause=1 for 4 cycles in S_RESP -> ready=1 and inst/inst_pc stable for all 4 cycles, no new bus_req.
- reset=0 asserted during S_BUS -> next cycle bus_req=0 and all outputs at their reset values. After release, a fresh fetch of the current pc is issued.
